// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read bus between the fetch unit and instruction memory.
//
// Parameters
//   PC_W     address width
//   INSTR_W  instruction word width
//
// Signals
//   im_req   fetch unit -> memory : read request
//   im_addr  fetch unit -> memory : read address (the current pc)
//   im_ack   memory -> fetch unit : im_data is valid this cycle
//   im_data  memory -> fetch unit : returned instruction word
//
// Modports
//   master   fetch unit side
//   slave    instruction memory side
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 15
);
    logic               im_req;
    logic [PC_W-1:0]    im_addr;
    logic               im_ack;
    logic [INSTR_W-1:0] im_data;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_data
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_data
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Requests the word at pc from instruction memory,
// latches it into the instruction register, presents opcode/literal to the
// execute stage and advances pc (sequentially or to a jump target) once the
// execute stage reports completion.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a fetch that waits TIMEOUT cycles without im_ack moves the
//   unit into a terminal error state and raises the sticky fetch_err flag.
//   When undefined, fetch waits forever and fetch_err is tied low.
//
// Parameters
//   PC_W      program counter / memory address width
//   INSTR_W   instruction width (opcode [14:8], literal [7:0])
//   TIMEOUT   maximum FETCH cycles without im_ack (FETCH_TIMEOUT_EN only)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   im           instruction-memory bus (master side)
//   opcode       registered opcode, IR[14:8]
//   lit          registered literal, IR[7:0]
//   instr_valid  opcode/lit hold the instruction being executed
//   exec_done    execute stage finished the current instruction
//   pc_load      taken branch: load pc from jmp_addr when exec_done
//   jmp_addr     jump target
//   pc           current program counter
//   fetch_err    sticky fetch timeout flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 15,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      im,
    output logic [6:0]        opcode,
    output logic [7:0]        lit,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              pc_load,
    input  logic [PC_W-1:0]   jmp_addr,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_err
);

    // A zero or negative timeout would make the error state unavoidable.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_ERR   = 2'b10
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_next;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_next;
    logic [INSTR_W-1:0] ir_r;
    logic [INSTR_W-1:0] ir_next;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Last counter value at which an ack is still accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next;
    logic               err_r;
    logic               err_next;
`endif

    // Next-state and next-datapath decode; every register holds by default.
    always_comb begin
        state_next = state_r;
        pc_next    = pc_r;
        ir_next    = ir_r;
`ifdef FETCH_TIMEOUT_EN
        cnt_next   = cnt_r;
        err_next   = err_r;
`endif
        case (state_r)
            ST_FETCH: begin
                if (im.im_ack) begin
                    // Ack is checked before the timeout, so an ack in the
                    // last allowed cycle still wins.
                    ir_next    = im.im_data;
                    state_next = ST_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_r == CNT_LAST) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
                else begin
                    cnt_next   = cnt_r + CNT_ONE;
                end
`else
                else begin
                    state_next = ST_FETCH;
                end
`endif
            end
            ST_EXEC: begin
                // pc_load/jmp_addr only matter together with exec_done.
                if (exec_done) begin
                    if (pc_load) begin
                        pc_next = jmp_addr;
                    end else begin
                        pc_next = pc_r + PC_ONE;
                    end
                    state_next = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    cnt_next   = CNT_ZERO;
`endif
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_ERR: begin
                // Terminal; only rst leaves this state.
                state_next = ST_ERR;
            end
            default: begin
                // Unused encoding: recover to a clean fetch.
                state_next = ST_FETCH;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next;
        end
    end

    // Program counter and instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= {PC_W{1'b0}};
            ir_r <= {INSTR_W{1'b0}};
        end else begin
            pc_r <= pc_next;
            ir_r <= ir_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Fetch wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next;
            err_r <= err_next;
        end
    end

    assign fetch_err = err_r;
`else
    assign fetch_err = 1'b0;
`endif

    // Outputs come straight from registers or from the state register.
    assign im.im_req   = (state_r == ST_FETCH);
    assign im.im_addr  = pc_r;
    assign pc          = pc_r;
    assign opcode      = ir_r[14:8];
    assign lit         = ir_r[7:0];
    assign instr_valid = (state_r == ST_EXEC);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed and randomized stimulus for fetch_unit, checked every cycle against
// a behavioural model of the fetch/execute handshake.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 15;
    localparam int TIMEOUT = 15;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [6:0]        opcode;
    logic [7:0]        lit;
    logic              instr_valid;
    logic              exec_done;
    logic              pc_load;
    logic [PC_W-1:0]   jmp_addr;
    logic [PC_W-1:0]   pc;
    logic              fetch_err;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) im_bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .im          (im_bus),
        .opcode      (opcode),
        .lit         (lit),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pc_load     (pc_load),
        .jmp_addr    (jmp_addr),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model: whether an instruction is being executed, the word
    // held for it, the program counter, consecutive unanswered fetch cycles
    // and whether the unit has given up.
    bit m_busy;
    bit m_err;
    int m_pc;
    int m_ir;
    int m_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("im_req",      32'(im_bus.im_req), 32'(!m_busy && !m_err));
        check("im_addr",     32'(im_bus.im_addr), m_pc);
        check("pc",          32'(pc), m_pc);
        check("opcode",      32'(opcode), (m_ir >> 8) & 32'h7F);
        check("lit",         32'(lit), m_ir & 32'hFF);
        check("instr_valid", 32'(instr_valid), 32'(m_busy));
        check("fetch_err",   32'(fetch_err), 32'(m_err));
    endtask

    // One clock: drive inputs, advance the model on the edge, then check.
    task automatic tick(input bit r, input bit a, input logic [14:0] d,
                        input bit ed, input bit pl, input logic [7:0] ja);
        rst              = r;
        im_bus.im_ack    = a;
        im_bus.im_data   = d;
        exec_done        = ed;
        pc_load          = pl;
        jmp_addr         = ja;
        @(posedge clk);
        if (r) begin
            m_pc = 0; m_ir = 0; m_busy = 0; m_err = 0; m_wait = 0;
        end else if (m_err) begin
            m_err = 1;
        end else if (!m_busy) begin
            if (a) begin
                m_ir   = int'(d);
                m_busy = 1;
            end else begin
                m_wait++;
                if (TO_EN && m_wait == TIMEOUT) m_err = 1;
            end
        end else if (ed) begin
            m_pc   = pl ? int'(ja) : (m_pc + 1) % 256;
            m_busy = 0;
            m_wait = 0;
        end
        #1;
        check_all();
    endtask

    logic [14:0] rd;

    initial begin
        rst = 1'b1; im_bus.im_ack = 1'b0; im_bus.im_data = 15'h0000;
        exec_done = 1'b0; pc_load = 1'b0; jmp_addr = 8'h00;
        m_pc = 0; m_ir = 0; m_busy = 0; m_err = 0; m_wait = 0;

        // Reset for two cycles with noisy inputs that must be ignored.
        tick(1'b1, 1'b1, 15'h7FFF, 1'b1, 1'b1, 8'hAA);
        tick(1'b1, 1'b1, 15'h1234, 1'b1, 1'b1, 8'h55);
        check("rst_im_req", 32'(im_bus.im_req), 32'h1);
        check("rst_im_addr", 32'(im_bus.im_addr), 32'h0);

        // Single instruction, best-case two-cycle throughput.
        tick(1'b0, 1'b1, 15'h0205, 1'b0, 1'b0, 8'h00);
        check("first_opcode", 32'(opcode), 32'h02);
        check("first_lit", 32'(lit), 32'h05);
        check("first_valid", 32'(instr_valid), 32'h1);
        tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 8'h00);
        check("first_next_addr", 32'(im_bus.im_addr), 32'h1);
        check("first_valid_drop", 32'(instr_valid), 32'h0);

        // Three instructions, exec_done on the third EXEC cycle; stray acks
        // and pc_load during EXEC must have no effect.
        for (int k = 0; k < 3; k++) begin
            rd = 15'($urandom);
            tick(1'b0, 1'b1, rd, 1'b0, 1'b0, 8'h00);
            tick(1'b0, 1'b1, 15'($urandom), 1'b0, 1'b1, 8'($urandom));
            tick(1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 8'($urandom));
            check("seq_opcode_stable", 32'(opcode), 32'(rd[14:8]));
            tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 8'h00);
        end
        check("seq_pc_after3", 32'(pc), 32'h4);

        // Taken branch to 0x40.
        tick(1'b0, 1'b1, 15'h0A11, 1'b0, 1'b1, 8'h77);
        tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 8'h40);
        check("jump_addr", 32'(im_bus.im_addr), 32'h40);

        // Wrap from 0xFF to 0x00 on a plain increment.
        tick(1'b0, 1'b1, 15'h0B22, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 8'hFF);
        tick(1'b0, 1'b1, 15'h0C33, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 8'h13);
        check("wrap_addr", 32'(im_bus.im_addr), 32'h0);

        // Reset during EXEC beats exec_done/pc_load.
        tick(1'b0, 1'b1, 15'h0D44, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 15'h0000, 1'b1, 1'b1, 8'h99);
        check("rst_exec_valid", 32'(instr_valid), 32'h0);
        check("rst_exec_pc", 32'(pc), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 15'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 8'($urandom));
        end

        // Fetch wait boundaries: ack on the last allowed cycle is accepted,
        // then a fetch that is never answered.
        tick(1'b1, 1'b0, 15'h0000, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 15'h0E55, 1'b0, 1'b0, 8'h00);
        check("late_ack_valid", 32'(instr_valid), 32'h1);
        tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < TIMEOUT + 25; i++) tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 8'h33);
        check("no_ack_err", 32'(fetch_err), 32'(TO_EN));
        check("no_ack_req", 32'(im_bus.im_req), 32'(!TO_EN));
        tick(1'b1, 1'b0, 15'h0000, 1'b0, 1'b0, 8'h00);
        check("err_cleared", 32'(fetch_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
